pipeline_scoreboard: RTL and testbench



---
 rtl/pipeline_scoreboard.sv | 136 +++++++++++++
 tb/tb_pipeline_scoreboard.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_scoreboard.sv
// Scoreboard for long-latency register writers: stalls Decode on RAW/WAW against pending results.
// Optional stall-cycle counter is compiled in with SCOREBOARD_PERF_EN.
module pipeline_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int LAT_W    = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                IssueValidD,
  input  logic [REG_AW-1:0]   Rs1D,
  input  logic [REG_AW-1:0]   Rs2D,
  input  logic [REG_AW-1:0]   RdD,
  input  logic                UseRs1D,
  input  logic                UseRs2D,
  input  logic [LAT_W-1:0]    IssueLatD,
  input  logic                PCSrcE,
  input  logic                CmplValid,
  input  logic [REG_AW-1:0]   CmplRd,
  output logic                StallF,
  output logic                StallD,
  output logic                FlushD,
  output logic                FlushE,
  output logic [NUM_REGS-1:0] BusyVec,
  output logic                ErrSpurious
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]         StallCycles
`endif
);

  localparam int              AW_SPAN = 1 << REG_AW;
  localparam logic [LAT_W-1:0] LAT_VAR = '1;
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  logic [LAT_W-1:0]   state_q [NUM_REGS];
  logic [LAT_W-1:0]   state_d [NUM_REGS];
  logic               err_q;

  // Flags over the full address space so out-of-range and x0 lookups read as zero.
  logic [AW_SPAN-1:0] busy_ext;
  logic [AW_SPAN-1:0] block_ext;
  logic [AW_SPAN-1:0] wait_ext;

  logic hazard;
  logic issue_fire;
  logic cmpl_hit;
  logic spurious;

  genvar gi;
  generate
    for (gi = 0; gi < AW_SPAN; gi++) begin : g_flag
      if (gi > 0 && gi < NUM_REGS) begin : g_live
        assign busy_ext[gi]  = (state_q[gi] != '0);
        // A countdown at 1 retires on this edge, so its consumer may issue alongside it.
        assign block_ext[gi] = (state_q[gi] != '0) && (state_q[gi] != LAT_ONE);
        assign wait_ext[gi]  = (state_q[gi] == LAT_VAR);
      end else begin : g_dead
        assign busy_ext[gi]  = 1'b0;
        assign block_ext[gi] = 1'b0;
        assign wait_ext[gi]  = 1'b0;
      end
    end
  endgenerate

  assign BusyVec = busy_ext[NUM_REGS-1:0];

  assign hazard = IssueValidD &
                  ((UseRs1D & block_ext[Rs1D]) |
                   (UseRs2D & block_ext[Rs2D]) |
                   ((RdD != '0) & block_ext[RdD]));

  assign StallF = hazard & ~PCSrcE;
  assign StallD = hazard & ~PCSrcE;
  assign FlushD = PCSrcE;
  assign FlushE = hazard | PCSrcE;

  assign issue_fire = IssueValidD & ~hazard & ~PCSrcE & (RdD != '0) & (IssueLatD != '0);
  assign cmpl_hit   = CmplValid & wait_ext[CmplRd];
  assign spurious   = CmplValid & ~wait_ext[CmplRd];

  always_comb begin
    state_d[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      state_d[r] = state_q[r];
      if (state_q[r] != '0 && state_q[r] != LAT_VAR) begin
        state_d[r] = state_q[r] - LAT_ONE;
      end
      if (cmpl_hit && CmplRd == REG_AW'(r)) begin
        state_d[r] = '0;
      end
      if (issue_fire && RdD == REG_AW'(r)) begin
        state_d[r] = IssueLatD;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        state_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        state_q[r] <= state_d[r];
      end
      err_q <= err_q | spurious;
    end
  end

  assign ErrSpurious = err_q;

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallD && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard: fixed/variable latency stalls, flush, WAW, spurious completion, reset.
module tb_pipeline_scoreboard;
  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 5;
  localparam int LAT_W    = 3;

  logic                clk;
  logic                resetn;
  logic                IssueValidD;
  logic [REG_AW-1:0]   Rs1D, Rs2D, RdD;
  logic                UseRs1D, UseRs2D;
  logic [LAT_W-1:0]    IssueLatD;
  logic                PCSrcE;
  logic                CmplValid;
  logic [REG_AW-1:0]   CmplRd;
  logic                StallF, StallD, FlushD, FlushE;
  logic [NUM_REGS-1:0] BusyVec;
  logic                ErrSpurious;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0]         StallCycles;
`endif

  int checks;
  int failures;

  pipeline_scoreboard #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .LAT_W(LAT_W)) dut (
    .clk(clk),
    .resetn(resetn),
    .IssueValidD(IssueValidD),
    .Rs1D(Rs1D),
    .Rs2D(Rs2D),
    .RdD(RdD),
    .UseRs1D(UseRs1D),
    .UseRs2D(UseRs2D),
    .IssueLatD(IssueLatD),
    .PCSrcE(PCSrcE),
    .CmplValid(CmplValid),
    .CmplRd(CmplRd),
    .StallF(StallF),
    .StallD(StallD),
    .FlushD(FlushD),
    .FlushE(FlushE),
    .BusyVec(BusyVec),
    .ErrSpurious(ErrSpurious)
`ifdef SCOREBOARD_PERF_EN
    ,
    .StallCycles(StallCycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic v, input logic [REG_AW-1:0] rs1, input logic u1,
                       input logic [REG_AW-1:0] rs2, input logic u2,
                       input logic [REG_AW-1:0] rd, input logic [LAT_W-1:0] lat);
    IssueValidD = v;
    Rs1D = rs1; UseRs1D = u1;
    Rs2D = rs2; UseRs2D = u2;
    RdD = rd;   IssueLatD = lat;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b1;
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0);
    PCSrcE = 1'b0;
    CmplValid = 1'b0;
    CmplRd = 5'd0;
    #1 resetn = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_busy", 64'(BusyVec), 64'h0);
    chk("rst_err", 64'(ErrSpurious), 64'h0);
    chk("rst_stallf", 64'(StallF), 64'h0);
    chk("rst_stalld", 64'(StallD), 64'h0);
    chk("rst_flushd", 64'(FlushD), 64'h0);
    chk("rst_flushe", 64'(FlushE), 64'h0);
    PCSrcE = 1'b1; #1;
    chk("rst_pcsrc_flushd", 64'(FlushD), 64'h1);
    chk("rst_pcsrc_flushe", 64'(FlushE), 64'h1);
    PCSrcE = 1'b0;
    resetn = 1'b1;
`ifdef SCOREBOARD_PERF_EN
    chk("perf_rst", 64'(StallCycles), 64'h0);
`endif

    // Stream of single-cycle writers: never tracked
    for (int i = 0; i < 4; i++) begin
      instr(1'b1, 5'd5, 1'b1, 5'(i + 1), 1'b1, 5'd5, 3'd0);
      tick();
      chk($sformatf("alu_stream_stall%0d", i), 64'(StallD), 64'h0);
      chk($sformatf("alu_stream_busy%0d", i), 64'(BusyVec), 64'h0);
    end

    // Writer to x0 is never tracked
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd4);
    tick();
    chk("x0_busy", 64'(BusyVec), 64'h0);
    instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 3'd0); #1;
    chk("x0_src_stall", 64'(StallD), 64'h0);

    // Fixed latency 3 on x5, dependent reads x5
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 3'd3); #1;
    chk("fix_issue_stall", 64'(StallD), 64'h0);
    tick();
    instr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 3'd0); #1;
    chk("fix_c1_busy", 64'(BusyVec), 64'h0020);
    chk("fix_c1_stalld", 64'(StallD), 64'h1);
    chk("fix_c1_stallf", 64'(StallF), 64'h1);
    chk("fix_c1_flushe", 64'(FlushE), 64'h1);
    tick();
    chk("fix_c2_busy", 64'(BusyVec), 64'h0020);
    chk("fix_c2_stalld", 64'(StallD), 64'h1);
    tick();
    chk("fix_c3_busy", 64'(BusyVec), 64'h0020);
    chk("fix_c3_stalld", 64'(StallD), 64'h0);
    chk("fix_c3_flushe", 64'(FlushE), 64'h0);
    tick();
    chk("fix_c4_busy", 64'(BusyVec), 64'h0);
`ifdef SCOREBOARD_PERF_EN
    chk("perf_fixed", 64'(StallCycles), 64'h2);
`endif

    // Variable latency on x7, dependent reads x7 via rs2 and writes x8 (lat 2)
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 3'd7);
    tick();
    instr(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 3'd2); #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("var_wait_stall%0d", i), 64'(StallD), 64'h1);
      chk($sformatf("var_wait_busy%0d", i), 64'(BusyVec), 64'h0080);
      tick();
    end
    PCSrcE = 1'b1; #1;
    chk("br_stalld", 64'(StallD), 64'h0);
    chk("br_stallf", 64'(StallF), 64'h0);
    chk("br_flushd", 64'(FlushD), 64'h1);
    chk("br_flushe", 64'(FlushE), 64'h1);
    tick();
    PCSrcE = 1'b0; #1;
    chk("br_busy_kept", 64'(BusyVec), 64'h0080);
    chk("br_after_stall", 64'(StallD), 64'h1);
    CmplValid = 1'b1; CmplRd = 5'd7; #1;
    chk("cmpl_same_cycle_stall", 64'(StallD), 64'h1);
    tick();
    CmplValid = 1'b0; #1;
    chk("cmpl_busy_fall", 64'(BusyVec), 64'h0);
    chk("cmpl_stall_clear", 64'(StallD), 64'h0);
    chk("cmpl_no_err", 64'(ErrSpurious), 64'h0);
    tick();
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0);
    chk("dep_issued_busy", 64'(BusyVec), 64'h0100);
    tick();
    chk("dep_busy_c2", 64'(BusyVec), 64'h0100);
    tick();
    chk("dep_busy_done", 64'(BusyVec), 64'h0);

    // WAW against a variable-latency x9
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 3'd7);
    tick();
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 3'd0); #1;
    chk("waw_stall", 64'(StallD), 64'h1);
    chk("waw_busy", 64'(BusyVec), 64'h0200);
    CmplValid = 1'b1; CmplRd = 5'd9;
    tick();
    CmplValid = 1'b0; #1;
    chk("waw_release_stall", 64'(StallD), 64'h0);
    chk("waw_release_busy", 64'(BusyVec), 64'h0);
    chk("waw_release_err", 64'(ErrSpurious), 64'h0);

    // Out-of-range source reads as not busy
    instr(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 3'd0); #1;
    chk("oor_src_stall", 64'(StallD), 64'h0);
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0);

    // Spurious completion to idle x3 is sticky
    CmplValid = 1'b1; CmplRd = 5'd3; #1;
    chk("spur_before_edge", 64'(ErrSpurious), 64'h0);
    tick();
    CmplValid = 1'b0; #1;
    chk("spur_set", 64'(ErrSpurious), 64'h1);
    repeat (2) tick();
    chk("spur_sticky", 64'(ErrSpurious), 64'h1);

    // Reset mid-operation clears pending entries asynchronously
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 3'd7);
    tick();
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0); #1;
    chk("midrst_busy_before", 64'(BusyVec), 64'h0080);
    resetn = 1'b0; #1;
    chk("midrst_busy", 64'(BusyVec), 64'h0);
    chk("midrst_err", 64'(ErrSpurious), 64'h0);
    tick();
    resetn = 1'b1;
    CmplValid = 1'b1; CmplRd = 5'd7;
    tick();
    CmplValid = 1'b0; #1;
    chk("late_cmpl_err", 64'(ErrSpurious), 64'h1);
    chk("late_cmpl_busy", 64'(BusyVec), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
